unidad_control_multiciclo: RTL and testbench

Multicycle control FSM for the MIPS datapath. It sequences fetch, decode (register read, sign extension, ALU-control lookup), execute, memory and write-back. From the latched opcode it drives every control input of the decode stage: `reg_escribir`, `destino_reg`, `alu_fuente`, `alu_op`, `mem_escribir`, `mem_leer`, `mem_a_reg`, `branch` and `salto`. It also drives the PC/IR enables and stalls on a ready handshake from unified instruction/data memory.

---
 rtl/mips_pkg.sv | 41 ++++
 rtl/unidad_control_multiciclo.sv | 165 ++++++++++++++++
 tb/tb_unidad_control_multiciclo.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - opcode, ALU-op, PC-source and state encodings for the multicycle MIPS control
package mips_pkg;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    localparam logic [1:0] ALUOP_SUMA  = 2'b00;
    localparam logic [1:0] ALUOP_RESTA = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCF_SUMA4 = 2'b00;
    localparam logic [1:0] PCF_RAMA  = 2'b01;
    localparam logic [1:0] PCF_SALTO = 2'b10;

    // Encodings double as the estado debug output
    typedef enum logic [3:0] {
        ESPERA       = 4'd0,
        FETCH        = 4'd1,
        DECODE       = 4'd2,
        DIR_MEM      = 4'd3,
        LEER_MEM     = 4'd4,
        ESCR_MEM_REG = 4'd5,
        ESCR_MEM     = 4'd6,
        EJEC_R       = 4'd7,
        ESCR_R       = 4'd8,
        EJEC_I       = 4'd9,
        ESCR_I       = 4'd10,
        RAMA         = 4'd11,
        SALTO        = 4'd12
    } estado_t;

    function automatic logic opcode_valido(input logic [5:0] op);
        return (op == OP_R) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/unidad_control_multiciclo.sv
// rtl/unidad_control_multiciclo.sv - multicycle MIPS control FSM with memory-ready stalls and retire counter
module unidad_control_multiciclo
    import mips_pkg::*;
#(
    parameter int ANCHO_CONT = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [5:0]            opcode,
    input  logic                  mem_listo,
    output logic                  pc_escribir,
    output logic                  ir_escribir,
    output logic                  iord,
    output logic [1:0]            pc_fuente,
    output logic                  alu_fuente_a,
    output logic                  reg_escribir,
    output logic                  destino_reg,
    output logic                  alu_fuente,
    output logic [1:0]            alu_op,
    output logic                  mem_escribir,
    output logic                  mem_leer,
    output logic                  mem_a_reg,
    output logic                  branch,
    output logic                  salto,
    output logic                  instr_ilegal,
    output logic [ANCHO_CONT-1:0] instr_retiradas,
    output logic [3:0]            estado
);

    estado_t estado_q;
    estado_t estado_d;
    // Remembers lw vs sw from DECODE so DIR_MEM does not depend on opcode
    logic    es_carga;

    assign estado = estado_q;

    // State register plus the load/store flag captured while decoding
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado_q <= ESPERA;
            es_carga <= 1'b0;
        end else begin
            estado_q <= estado_d;
            if (estado_q == DECODE) begin
                es_carga <= (opcode == OP_LW);
            end
        end
    end

    // Next-state selection
    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            ESPERA:       estado_d = FETCH;
            FETCH:        if (mem_listo) estado_d = DECODE;
            DECODE: begin
                case (opcode)
                    OP_R:         estado_d = EJEC_R;
                    OP_LW, OP_SW: estado_d = DIR_MEM;
                    OP_BEQ:       estado_d = RAMA;
                    OP_J:         estado_d = SALTO;
                    OP_ADDI:      estado_d = EJEC_I;
                    default:      estado_d = FETCH;
                endcase
            end
            DIR_MEM:      estado_d = es_carga ? LEER_MEM : ESCR_MEM;
            LEER_MEM:     if (mem_listo) estado_d = ESCR_MEM_REG;
            ESCR_MEM_REG: estado_d = FETCH;
            ESCR_MEM:     if (mem_listo) estado_d = FETCH;
            EJEC_R:       estado_d = ESCR_R;
            ESCR_R:       estado_d = FETCH;
            EJEC_I:       estado_d = ESCR_I;
            ESCR_I:       estado_d = FETCH;
            RAMA:         estado_d = FETCH;
            SALTO:        estado_d = FETCH;
            default:      estado_d = ESPERA;
        endcase
    end

    // Moore output decode; only the FETCH write enables look at mem_listo
    always_comb begin
        pc_escribir  = 1'b0;
        ir_escribir  = 1'b0;
        iord         = 1'b0;
        pc_fuente    = PCF_SUMA4;
        alu_fuente_a = 1'b0;
        reg_escribir = 1'b0;
        destino_reg  = 1'b0;
        alu_fuente   = 1'b0;
        alu_op       = ALUOP_SUMA;
        mem_escribir = 1'b0;
        mem_leer     = 1'b0;
        mem_a_reg    = 1'b0;
        branch       = 1'b0;
        salto        = 1'b0;
        instr_ilegal = 1'b0;
        case (estado_q)
            FETCH: begin
                mem_leer    = 1'b1;
                ir_escribir = mem_listo;
                pc_escribir = mem_listo;
            end
            DECODE: begin
                alu_fuente   = 1'b1;
                instr_ilegal = !opcode_valido(opcode);
            end
            DIR_MEM, EJEC_I: begin
                alu_fuente_a = 1'b1;
                alu_fuente   = 1'b1;
            end
            LEER_MEM: begin
                mem_leer = 1'b1;
                iord     = 1'b1;
            end
            ESCR_MEM_REG: begin
                reg_escribir = 1'b1;
                mem_a_reg    = 1'b1;
            end
            ESCR_MEM: begin
                mem_escribir = 1'b1;
                iord         = 1'b1;
            end
            EJEC_R: begin
                alu_fuente_a = 1'b1;
                alu_op       = ALUOP_FUNCT;
            end
            ESCR_R: begin
                reg_escribir = 1'b1;
                destino_reg  = 1'b1;
            end
            ESCR_I: begin
                reg_escribir = 1'b1;
            end
            RAMA: begin
                alu_fuente_a = 1'b1;
                alu_op       = ALUOP_RESTA;
                branch       = 1'b1;
                pc_fuente    = PCF_RAMA;
            end
            SALTO: begin
                salto       = 1'b1;
                pc_escribir = 1'b1;
                pc_fuente   = PCF_SALTO;
            end
            default: ;
        endcase
    end

    // Retired-instruction counter, bumped as each instruction's final state is left
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_retiradas <= '0;
        end else begin
            case (estado_q)
                ESCR_MEM_REG, ESCR_R, ESCR_I, RAMA, SALTO:
                    instr_retiradas <= instr_retiradas + {{(ANCHO_CONT-1){1'b0}}, 1'b1};
                ESCR_MEM:
                    if (mem_listo)
                        instr_retiradas <= instr_retiradas + {{(ANCHO_CONT-1){1'b0}}, 1'b1};
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_unidad_control_multiciclo.sv
// tb/tb_unidad_control_multiciclo.sv - table-driven bench for the multicycle MIPS control FSM
module tb_unidad_control_multiciclo;

    localparam int AC = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [5:0]    opcode;
    logic          mem_listo;
    logic          pc_escribir, ir_escribir, iord, alu_fuente_a;
    logic          reg_escribir, destino_reg, alu_fuente, mem_escribir;
    logic          mem_leer, mem_a_reg, branch, salto, instr_ilegal;
    logic [1:0]    pc_fuente, alu_op;
    logic [AC-1:0] instr_retiradas;
    logic [3:0]    estado;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    unidad_control_multiciclo #(.ANCHO_CONT(AC)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_listo(mem_listo),
        .pc_escribir(pc_escribir), .ir_escribir(ir_escribir), .iord(iord),
        .pc_fuente(pc_fuente), .alu_fuente_a(alu_fuente_a),
        .reg_escribir(reg_escribir), .destino_reg(destino_reg),
        .alu_fuente(alu_fuente), .alu_op(alu_op), .mem_escribir(mem_escribir),
        .mem_leer(mem_leer), .mem_a_reg(mem_a_reg), .branch(branch),
        .salto(salto), .instr_ilegal(instr_ilegal),
        .instr_retiradas(instr_retiradas), .estado(estado)
    );

    // {pcw, irw, iord, pcf[2], afa, rw, dr, af, mw, mr, m2r, br, sj, aop[2], il}
    function automatic logic [17:0] mk(input logic pcw, irw, io, input logic [1:0] pcf,
                                       input logic afa, rw, dr, af, mw, mr, m2r, br, sj,
                                       input logic [1:0] aop, input logic il);
        return {pcw, irw, io, pcf, afa, rw, dr, af, mw, mr, m2r, br, sj, aop, il};
    endfunction

    function automatic logic [17:0] ctl_actual();
        return {pc_escribir, ir_escribir, iord, pc_fuente, alu_fuente_a, reg_escribir,
                destino_reg, alu_fuente, mem_escribir, mem_leer, mem_a_reg, branch,
                salto, alu_op, instr_ilegal};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    typedef struct {
        logic [5:0]    op;
        logic          ml;
        logic [3:0]    st;
        logic [17:0]   ctl;
        logic [AC-1:0] cnt;
    } vec_t;

    vec_t tabla[31];

    initial begin
        logic [17:0] c_cero, c_fetch_w, c_fetch, c_dec, c_dec_il, c_dir, c_leer, c_emr;
        logic [17:0] c_emem, c_ejr, c_er, c_eji, c_ei, c_rama, c_salto;
        //             pcw irw io pcf   afa rw dr af mw mr m2r br sj aop   il
        c_cero    = '0;
        c_fetch_w = mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 0);
        c_fetch   = mk(1, 1, 0, 2'b00, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 0);
        c_dec     = mk(0, 0, 0, 2'b00, 0, 0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 0);
        c_dec_il  = mk(0, 0, 0, 2'b00, 0, 0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 1);
        c_dir     = mk(0, 0, 0, 2'b00, 1, 0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 0);
        c_leer    = mk(0, 0, 1, 2'b00, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 0);
        c_emr     = mk(0, 0, 0, 2'b00, 0, 1, 0, 0, 0, 0, 1, 0, 0, 2'b00, 0);
        c_emem    = mk(0, 0, 1, 2'b00, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 0);
        c_ejr     = mk(0, 0, 0, 2'b00, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 0);
        c_er      = mk(0, 0, 0, 2'b00, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 0);
        c_eji     = c_dir;
        c_ei      = mk(0, 0, 0, 2'b00, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
        c_rama    = mk(0, 0, 0, 2'b01, 1, 0, 0, 0, 0, 0, 0, 1, 0, 2'b01, 0);
        c_salto   = mk(1, 0, 0, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0);

        // Cycle-by-cycle: reset release, R, lw (3 waits), sw, beq, j, illegal, addi
        tabla[0]  = '{6'o00, 1, 4'd0,  c_cero,   4'd0};
        tabla[1]  = '{6'o00, 1, 4'd1,  c_fetch,  4'd0};
        tabla[2]  = '{6'b000000, 1, 4'd2, c_dec, 4'd0};
        tabla[3]  = '{6'b000000, 1, 4'd7, c_ejr, 4'd0};
        tabla[4]  = '{6'b000000, 1, 4'd8, c_er,  4'd0};
        tabla[5]  = '{6'b100011, 1, 4'd1, c_fetch, 4'd1};
        tabla[6]  = '{6'b100011, 1, 4'd2, c_dec,   4'd1};
        tabla[7]  = '{6'b100011, 1, 4'd3, c_dir,   4'd1};
        tabla[8]  = '{6'b100011, 0, 4'd4, c_leer,  4'd1};
        tabla[9]  = '{6'b100011, 0, 4'd4, c_leer,  4'd1};
        tabla[10] = '{6'b100011, 0, 4'd4, c_leer,  4'd1};
        tabla[11] = '{6'b100011, 1, 4'd4, c_leer,  4'd1};
        tabla[12] = '{6'b100011, 1, 4'd5, c_emr,   4'd1};
        tabla[13] = '{6'b101011, 1, 4'd1, c_fetch, 4'd2};
        tabla[14] = '{6'b101011, 1, 4'd2, c_dec,   4'd2};
        tabla[15] = '{6'b101011, 1, 4'd3, c_dir,   4'd2};
        tabla[16] = '{6'b101011, 1, 4'd6, c_emem,  4'd2};
        tabla[17] = '{6'b000100, 1, 4'd1, c_fetch, 4'd3};
        tabla[18] = '{6'b000100, 1, 4'd2, c_dec,   4'd3};
        tabla[19] = '{6'b000100, 1, 4'd11, c_rama, 4'd3};
        tabla[20] = '{6'b000010, 1, 4'd1, c_fetch, 4'd4};
        tabla[21] = '{6'b000010, 1, 4'd2, c_dec,   4'd4};
        tabla[22] = '{6'b000010, 1, 4'd12, c_salto, 4'd4};
        tabla[23] = '{6'b111111, 1, 4'd1, c_fetch, 4'd5};
        tabla[24] = '{6'b111111, 1, 4'd2, c_dec_il, 4'd5};
        tabla[25] = '{6'b001000, 0, 4'd1, c_fetch_w, 4'd5};
        tabla[26] = '{6'b001000, 1, 4'd1, c_fetch, 4'd5};
        tabla[27] = '{6'b001000, 0, 4'd2, c_dec,   4'd5};
        tabla[28] = '{6'b001000, 0, 4'd9, c_eji,   4'd5};
        tabla[29] = '{6'b001000, 1, 4'd10, c_ei,   4'd5};
        tabla[30] = '{6'b101011, 1, 4'd1, c_fetch, 4'd6};

        reset     = 1'b1;
        opcode    = 6'b0;
        mem_listo = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_estado", estado, 4'd0);
        check("reset_ctl", ctl_actual(), c_cero);
        check("reset_cnt", instr_retiradas, 4'd0);

        for (int i = 0; i < 31; i++) begin
            @(negedge clk);
            reset     = 1'b0;
            opcode    = tabla[i].op;
            mem_listo = tabla[i].ml;
            #1;
            check($sformatf("row%0d_estado", i), estado, tabla[i].st);
            check($sformatf("row%0d_ctl", i), ctl_actual(), tabla[i].ctl);
            check($sformatf("row%0d_cnt", i), instr_retiradas, tabla[i].cnt);
        end

        // sw stalled in ESCR_MEM, then reset lands mid-access
        @(negedge clk); opcode = 6'b101011; mem_listo = 1'b0;   // DECODE
        @(negedge clk);                                         // DIR_MEM
        @(negedge clk); #1;                                     // ESCR_MEM
        check("sw_stall_estado", estado, 4'd6);
        check("sw_stall_mw", mem_escribir, 1'b1);
        @(negedge clk); #1;
        check("sw_stall_hold", estado, 4'd6);
        reset = 1'b1;
        #1;
        check("rst_mid_estado", estado, 4'd0);
        check("rst_mid_ctl", ctl_actual(), c_cero);
        check("rst_mid_cnt", instr_retiradas, 4'd0);
        @(negedge clk); #1;
        check("rst_hold_ctl", ctl_actual(), c_cero);
        @(negedge clk);
        reset = 1'b0; mem_listo = 1'b1; opcode = 6'b001000;
        #1;
        check("rel_espera", estado, 4'd0);
        @(negedge clk); #1;
        check("rel_fetch", estado, 4'd1);

        // 16 addi: counter wraps through all-ones back to zero
        for (int k = 1; k <= 16; k++) begin
            repeat (4) @(negedge clk);
            #1;
            if (k == 15) check("wrap_ffff", instr_retiradas, 4'd15);
            if (k == 16) check("wrap_zero", instr_retiradas, 4'd0);
        end
        check("wrap_fetch", estado, 4'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
